direction_buttons_debounce: RTL
===============================

// Module: direction_buttons_debounce
// PURPOSE
//  Synchronises and debounces the four raw direction push-buttons (board KEY pins).
//  Delivers clean active-high levels to the direction-buttons PIO in_port[3:0].
//  Also emits one-cycle press/release event pulses for future IRQ or edge-capture use.
//  Sits between the top-level button pins and the Avalon PIO input; one instance per button group.
// PARAMETERS
//  N_BUTTONS        4       number of independent button channels
//  DEBOUNCE_CYCLES  500000  consecutive stable clk cycles required to accept a change (10 ms @ 50 MHz); legal range >= 2
//  ACTIVE_LOW       1       1: raw pin low = pressed; 0: raw pin high = pressed
//  CNT_W            $clog2(DEBOUNCE_CYCLES)+1  counter width (derived, not overridden)
// PORTS
//  clk            in   1          system clock, same domain as the PIO
//  reset_n        in   1          asynchronous reset, active low
//  buttons_raw    in   N_BUTTONS  raw asynchronous button pins, polarity per ACTIVE_LOW
//  buttons_db     out  N_BUTTONS  debounced level, always active-high (1 = pressed); drives PIO in_port
//  press_pulse    out  N_BUTTONS  1-cycle pulse when a channel's debounced level goes 0->1
//  release_pulse  out  N_BUTTONS  1-cycle pulse when a channel's debounced level goes 1->0
// BEHAVIOUR
//  Reset (async assert, sync release by the system reset controller):
//   - sync stages load the inactive level.
//   - counters = 0; buttons_db = 0; press_pulse = 0; release_pulse = 0.
//  Input normalisation:
//   - norm = ACTIVE_LOW ? ~buttons_raw : buttons_raw.
//   - norm passes through a 2-FF synchroniser per bit (sync1, sync2); no logic between the FFs.
//  Per-channel state (counter-based, channels fully independent):
//   - STABLE: sync2 == buttons_db.
//     - cnt <= 0.
//   - PENDING: sync2 != buttons_db.
//     - If cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
//     - If cnt == DEBOUNCE_CYCLES-1: buttons_db <= sync2; cnt <= 0; fire the matching pulse.
//   - Any single cycle with sync2 == buttons_db during PENDING (bounce) clears cnt.
//     - Accepting a change therefore needs DEBOUNCE_CYCLES consecutive mismatching cycles.
//  Pulses:
//   - press_pulse[i] / release_pulse[i] are registered.
//   - They are high exactly in the cycle buttons_db[i] first shows the new value, low otherwise.
//   - Never both high on the same channel.
//  Latency:
//   - Clean edge on buttons_raw to buttons_db change = 2 + DEBOUNCE_CYCLES clk edges.
//   - Pulse coincides with the buttons_db change.
//  Boundary conditions:
//   - Simultaneous changes on several channels are handled in parallel, with identical latency per channel.
//   - Glitches shorter than DEBOUNCE_CYCLES never reach buttons_db or the pulses.
//   - cnt never exceeds DEBOUNCE_CYCLES-1; no wrap-around.
//   - Reset mid-PENDING: the pending change is discarded.
//     - After release, a held button is re-accepted after the full latency from reset release.
//   - A button held through reset produces a press_pulse once accepted after reset.
//  No combinational path from buttons_raw to any output.
// TESTING (sim with DEBOUNCE_CYCLES=8, ACTIVE_LOW=1)
//  1. Reset: reset_n=0 with raw=4'b0000 -> buttons_db=0, pulses=0, held during reset; after release, db=4'b1111 at cycle 10 with one press_pulse=4'b1111.
//  2. Clean press ch0: raw 4'b1111->4'b1110 -> buttons_db=4'b0001 exactly 10 clk later; press_pulse=4'b0001 for 1 cycle.
//  3. Bounce ch2: toggle raw[2] every 3 cycles for 30 cycles, then hold low -> no change during bounce; db[2]=1 10 cycles after the final edge.
//  4. Release ch0: after test 2, raw[0]->1 -> db[0]=0 after 10 cycles; release_pulse=4'b0001 for 1 cycle; press_pulse stays 0.
//  5. Simultaneous: raw 4'b1111->4'b0101 -> db=4'b1010 and press_pulse=4'b1010, same cycle.
//  6. Reset mid-PENDING: press ch3, assert reset_n at cycle 5 for 2 cycles, keep pressed -> db[3]=1 exactly 10 cycles after reset release.

Source files
------------

// File: rtl/direction_buttons_debounce.sv
// Synchronise and debounce raw push-buttons into clean active-high levels plus press/release pulses.
// Latency: 2 + DEBOUNCE_CYCLES clk edges from a clean raw edge to buttons_db and the matching pulse.
// Backpressure: none; free-running per channel, every output is a registered level or one-cycle pulse.
module direction_buttons_debounce #(
    parameter int N_BUTTONS       = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_BUTTONS-1:0] buttons_raw,
    output logic [N_BUTTONS-1:0] buttons_db,
    output logic [N_BUTTONS-1:0] press_pulse,
    output logic [N_BUTTONS-1:0] release_pulse
);

    // Counter wide enough to hold DEBOUNCE_CYCLES-1 without wrapping.
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Normalised so that 1 always means "pressed"; inversion sits ahead of the
    // first flop so the synchroniser pair itself has nothing between the FFs.
    logic [N_BUTTONS-1:0] norm;
    assign norm = ACTIVE_LOW ? ~buttons_raw : buttons_raw;

    logic [N_BUTTONS-1:0] sync1_q;
    logic [N_BUTTONS-1:0] sync2_q;
    logic [N_BUTTONS-1:0] db_q,      db_d;
    logic [N_BUTTONS-1:0] press_q,   press_d;
    logic [N_BUTTONS-1:0] release_q, release_d;
    logic [CNT_W-1:0]     cnt_q [N_BUTTONS];
    logic [CNT_W-1:0]     cnt_d [N_BUTTONS];

    // Two-flop synchroniser; reset loads the released (inactive) level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= norm;
            sync2_q <= sync1_q;
        end
    end

    // Per-channel debounce: count consecutive mismatching cycles, any match
    // (bounce) clears the count, and the last allowed count accepts the change.
    always_comb begin
        db_d      = db_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < N_BUTTONS; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    db_d[i]      = sync2_q[i];
                    press_d[i]   = sync2_q[i];
                    release_d[i] = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Debounce state and pulse registers; pulses land in the same cycle as the level change.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_q      <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < N_BUTTONS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            db_q      <= db_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int i = 0; i < N_BUTTONS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign buttons_db    = db_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

endmodule
